// File: rtl/sync_route_issuer.sv
// Request queue feeding a two-way selector: one drive pulse per queued destination, then wait for free.
// Optional watchdog abort in WAIT is compiled in with `define ROUTE_ISSUER_TIMEOUT_EN.
module sync_route_issuer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic       i_dest,
  output logic       o_drive,
  output logic [1:0] o_select,
  input  logic       i_free,
  output logic       o_busy,
  output logic [7:0] o_issued0,
  output logic [7:0] o_issued1,
  output logic       o_timeout,
  output logic [1:0] dbgState
);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
    $error("sync_route_issuer: DEPTH must be a power of two in 2..16");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : gBadTimeout
    $error("sync_route_issuer: TIMEOUT must be in 1..255");
  end

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WAIT  = 2'd2
  } stateType;

  stateType       state, stateNext;
  logic [1:0]     selectReg, selectNext;
  logic [DEPTH-1:0] destMem;
  logic [AW-1:0]  wrPtr, rdPtr;
  logic [AW:0]    count;
  logic           full, empty, push, pop, popDone, wdExpire, headDest;

  // Handshake: a request transfers on any rising edge where i_valid and o_ready
  // are both high; o_ready comes only from the registered count, never from i_valid.
  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign o_ready  = !full;
  assign push     = i_valid && !full;
  assign pop      = popDone || wdExpire;
  assign headDest = destMem[rdPtr];

  always_ff @(posedge clk) begin
    if (push) destMem[wrPtr] <= i_dest;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef ROUTE_ISSUER_TIMEOUT_EN
  logic [7:0] wdCount;
  logic       timeoutFlag;

  // Expiry only counts when i_free is absent, so a late free still completes normally.
  assign wdExpire  = (state == WAIT) && !i_free && (wdCount == 8'(TIMEOUT - 1));
  assign o_timeout = timeoutFlag;

  always_ff @(posedge clk) begin
    if (rst) begin
      wdCount     <= '0;
      timeoutFlag <= 1'b0;
    end else begin
      if (state == DRIVE) wdCount <= '0;
      else if (state == WAIT && !i_free) wdCount <= wdCount + 8'd1;
      if (wdExpire) timeoutFlag <= 1'b1;
    end
  end
`else
  assign wdExpire  = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      selectReg <= 2'b00;
      o_issued0 <= 8'd0;
      o_issued1 <= 8'd0;
    end else begin
      state     <= stateNext;
      selectReg <= selectNext;
      if (popDone) begin
        if (headDest) o_issued1 <= o_issued1 + 8'd1;
        else          o_issued0 <= o_issued0 + 8'd1;
      end
    end
  end

  // The head entry stays in the FIFO until completion, so headDest is stable through WAIT.
  always_comb begin
    stateNext  = state;
    selectNext = selectReg;
    popDone    = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          stateNext  = DRIVE;
          selectNext = headDest ? 2'b10 : 2'b01;
        end
      end
      DRIVE: stateNext = WAIT;
      WAIT: begin
        if (i_free) begin
          popDone    = 1'b1;
          stateNext  = IDLE;
          selectNext = 2'b00;
        end else if (wdExpire) begin
          stateNext  = IDLE;
          selectNext = 2'b00;
        end
      end
      default: begin
        stateNext  = IDLE;
        selectNext = 2'b00;
      end
    endcase
  end

  assign o_drive  = (state == DRIVE);
  assign o_select = selectReg;
  assign o_busy   = (state != IDLE);
  assign dbgState = state;

endmodule

// File: tb/tb_sync_route_issuer.sv
// Directed bench for sync_route_issuer: reset, single issue, backpressure, alternating routes,
// stray free pulses, reset mid-transaction and (when compiled in) the watchdog.
module tb_sync_route_issuer;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_DRIVE = 2'd1, ST_WAIT = 2'd2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_valid = 1'b0, i_dest = 1'b0, i_free = 1'b0;
  logic       o_ready, o_drive, o_busy, o_timeout;
  logic [1:0] o_select, dbgState;
  logic [7:0] o_issued0, o_issued1;

  int checks = 0;
  int failures = 0;
  logic [1:0] exp_q[$];

  sync_route_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_dest(i_dest),
    .o_drive(o_drive), .o_select(o_select), .i_free(i_free), .o_busy(o_busy),
    .o_issued0(o_issued0), .o_issued1(o_issued1), .o_timeout(o_timeout), .dbgState(dbgState)
  );

  // clock/reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; i_valid = 1'b0; i_dest = 1'b0; i_free = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_for_wait(input string name);
    int n = 0;
    while (dbgState !== ST_WAIT && n < 10) begin tick(); n++; end
    checks++; if (dbgState !== ST_WAIT) begin failures++; $display("FAIL %s_reach_wait: state %0d want %0d", name, dbgState, ST_WAIT); end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    checks++; if (o_drive !== 1'b0) begin failures++; $display("FAIL reset_drive: got %b want 0", o_drive); end
    checks++; if (o_select !== 2'b00) begin failures++; $display("FAIL reset_select: got %b want 00", o_select); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    checks++; if (o_issued0 !== 8'd0 || o_issued1 !== 8'd0) begin failures++; $display("FAIL reset_issued: got %0d/%0d want 0/0", o_issued0, o_issued1); end
    checks++; if (o_timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b want 0", o_timeout); end
  endtask

  // One dest=1 request, free returned on the second WAIT cycle.
  task automatic test_single();
    apply_reset();
    i_valid = 1'b1; i_dest = 1'b1;
    tick();                          // push edge N
    i_valid = 1'b0;
    checks++; if (o_drive !== 1'b0 || o_select !== 2'b00) begin failures++; $display("FAIL single_idle: drive %b sel %b want 0 00", o_drive, o_select); end
    tick();                          // edge N+1: DRIVE
    checks++; if (o_drive !== 1'b1) begin failures++; $display("FAIL single_drive: got %b want 1", o_drive); end
    checks++; if (o_select !== 2'b10) begin failures++; $display("FAIL single_sel_drive: got %b want 10", o_select); end
    tick();                          // WAIT cycle 1
    checks++; if (o_drive !== 1'b0 || o_select !== 2'b10) begin failures++; $display("FAIL single_wait1: drive %b sel %b want 0 10", o_drive, o_select); end
    tick();                          // WAIT cycle 2
    checks++; if (o_select !== 2'b10 || dbgState !== ST_WAIT) begin failures++; $display("FAIL single_wait2: sel %b state %0d want 10 %0d", o_select, dbgState, ST_WAIT); end
    i_free = 1'b1;
    tick();
    i_free = 1'b0;
    checks++; if (o_issued1 !== 8'd1 || o_issued0 !== 8'd0) begin failures++; $display("FAIL single_issued: got %0d/%0d want 0/1", o_issued0, o_issued1); end
    checks++; if (o_select !== 2'b00 || o_busy !== 1'b0) begin failures++; $display("FAIL single_after: sel %b busy %b want 00 0", o_select, o_busy); end
  endtask

  // Five pushes into a 4-deep queue with free held low.
  task automatic test_full();
    apply_reset();
    i_valid = 1'b1; i_dest = 1'b0;
    tick();
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL full_ready_1: got %b want 1", o_ready); end
    tick(); tick(); tick();
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL full_ready_4: got %b want 0", o_ready); end
    tick(); tick(); tick();
    checks++; if (o_ready !== 1'b0 || dbgState !== ST_WAIT) begin failures++; $display("FAIL full_stall: ready %b state %0d want 0 %0d", o_ready, dbgState, ST_WAIT); end
    i_free = 1'b1;
    tick();                          // first completion, no push while full
    i_free = 1'b0;
    checks++; if (o_ready !== 1'b1 || o_issued0 !== 8'd1) begin failures++; $display("FAIL full_first_pop: ready %b issued0 %0d want 1 1", o_ready, o_issued0); end
    tick();                          // fifth request accepted
    i_valid = 1'b0;
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL full_fifth_push: ready %b want 0", o_ready); end
    for (int k = 0; k < 4; k++) begin
      wait_for_wait("full_drain");
      i_free = 1'b1;
      tick();
      i_free = 1'b0;
    end
    checks++; if (o_issued0 !== 8'd5 || o_ready !== 1'b1 || o_busy !== 1'b0) begin failures++; $display("FAIL full_drained: issued0 %0d ready %b busy %b want 5 1 0", o_issued0, o_ready, o_busy); end
  endtask

  // Alternating destinations, free one cycle after each drive.
  task automatic test_back_to_back();
    logic dests[4];
    logic freeNext;
    logic [1:0] curSel;
    int lastDrive, nDrive;
    logic [1:0] want;
    dests = '{1'b0, 1'b1, 1'b0, 1'b1};
    apply_reset();
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back(dests[k] ? 2'b10 : 2'b01);
    i_valid = 1'b1; i_dest = dests[0];
    freeNext = 1'b0; curSel = 2'b00; lastDrive = 0; nDrive = 0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      tick();
      i_free = freeNext;
      freeNext = o_drive;
      if (cyc < 4) i_dest = dests[cyc];
      else i_valid = 1'b0;
      if (o_drive === 1'b1) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
        checks++; if (o_select !== want) begin failures++; $display("FAIL b2b_select: drive %0d got %b want %b", nDrive, o_select, want); end
        if (nDrive == 0) begin
          checks++; if (cyc != 2) begin failures++; $display("FAIL b2b_latency: drive at cycle %0d want 2", cyc); end
        end else begin
          checks++; if (cyc - lastDrive != 3) begin failures++; $display("FAIL b2b_spacing: got %0d want 3", cyc - lastDrive); end
        end
        lastDrive = cyc; nDrive++; curSel = o_select;
      end else if (dbgState === ST_WAIT) begin
        checks++; if (o_select !== curSel) begin failures++; $display("FAIL b2b_hold: got %b want %b", o_select, curSel); end
      end else begin
        checks++; if (o_select !== 2'b00) begin failures++; $display("FAIL b2b_idle_sel: got %b want 00", o_select); end
      end
    end
    i_free = 1'b0;
    checks++; if (nDrive != 4 || exp_q.size() != 0) begin failures++; $display("FAIL b2b_count: drives %0d left %0d want 4 0", nDrive, exp_q.size()); end
    checks++; if (o_issued0 !== 8'd2 || o_issued1 !== 8'd2) begin failures++; $display("FAIL b2b_issued: got %0d/%0d want 2/2", o_issued0, o_issued1); end
  endtask

  // Free pulses in IDLE and DRIVE must not complete anything.
  task automatic test_free_ignored();
    apply_reset();
    i_free = 1'b1;
    tick();
    checks++; if (o_busy !== 1'b0 || o_issued0 !== 8'd0) begin failures++; $display("FAIL ign_empty: busy %b issued0 %0d want 0 0", o_busy, o_issued0); end
    i_valid = 1'b1; i_dest = 1'b0;
    tick();                          // push; next cycle IDLE with entry, free high
    i_valid = 1'b0;
    tick();                          // DRIVE, free still high
    checks++; if (o_drive !== 1'b1) begin failures++; $display("FAIL ign_drive: got %b want 1", o_drive); end
    tick();
    i_free = 1'b0;
    checks++; if (dbgState !== ST_WAIT || o_select !== 2'b01 || o_issued0 !== 8'd0) begin failures++; $display("FAIL ign_wait: state %0d sel %b issued0 %0d want %0d 01 0", dbgState, o_select, o_issued0, ST_WAIT); end
    tick(); tick();
    checks++; if (dbgState !== ST_WAIT) begin failures++; $display("FAIL ign_stays: state %0d want %0d", dbgState, ST_WAIT); end
    i_free = 1'b1;
    tick();
    i_free = 1'b0;
    checks++; if (o_issued0 !== 8'd1 || o_busy !== 1'b0) begin failures++; $display("FAIL ign_complete: issued0 %0d busy %b want 1 0", o_issued0, o_busy); end
  endtask

  // Reset in WAIT with the in-flight entry plus three queued.
  task automatic test_reset_mid();
    logic dests[4];
    dests = '{1'b1, 1'b0, 1'b1, 1'b0};
    apply_reset();
    i_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_dest = dests[k];
      tick();
    end
    i_valid = 1'b0;
    checks++; if (dbgState !== ST_WAIT || o_ready !== 1'b0) begin failures++; $display("FAIL mid_setup: state %0d ready %b want %0d 0", dbgState, o_ready, ST_WAIT); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_drive !== 1'b0 || o_select !== 2'b00) begin failures++; $display("FAIL mid_reset: ready %b busy %b drive %b sel %b want 1 0 0 00", o_ready, o_busy, o_drive, o_select); end
    checks++; if (o_issued0 !== 8'd0 || o_issued1 !== 8'd0 || o_timeout !== 1'b0) begin failures++; $display("FAIL mid_reset_cnt: %0d/%0d to %b want 0/0 0", o_issued0, o_issued1, o_timeout); end
    i_free = 1'b1;
    tick();
    i_free = 1'b0;
    tick(); tick();
    checks++; if (o_busy !== 1'b0 || o_issued0 !== 8'd0 || o_issued1 !== 8'd0) begin failures++; $display("FAIL mid_discard: busy %b issued %0d/%0d want 0 0/0", o_busy, o_issued0, o_issued1); end
  endtask

`ifdef ROUTE_ISSUER_TIMEOUT_EN
  // Watchdog drops a stuck dest=1 entry, then the queued dest=0 entry issues.
  task automatic test_timeout();
    apply_reset();
    i_valid = 1'b1; i_dest = 1'b1;
    tick();
    i_dest = 1'b0;
    tick();                          // DRIVE for first entry
    i_valid = 1'b0;
    for (int k = 0; k < TIMEOUT; k++) tick();   // ends on WAIT cycle TIMEOUT
    checks++; if (o_timeout !== 1'b0 || dbgState !== ST_WAIT) begin failures++; $display("FAIL to_before: timeout %b state %0d want 0 %0d", o_timeout, dbgState, ST_WAIT); end
    tick();
    checks++; if (o_timeout !== 1'b1 || o_busy !== 1'b0 || o_select !== 2'b00) begin failures++; $display("FAIL to_expire: timeout %b busy %b sel %b want 1 0 00", o_timeout, o_busy, o_select); end
    checks++; if (o_issued0 !== 8'd0 || o_issued1 !== 8'd0) begin failures++; $display("FAIL to_counts: %0d/%0d want 0/0", o_issued0, o_issued1); end
    tick();
    checks++; if (o_drive !== 1'b1 || o_select !== 2'b01) begin failures++; $display("FAIL to_next: drive %b sel %b want 1 01", o_drive, o_select); end
    tick();
    i_free = 1'b1;
    tick();
    i_free = 1'b0;
    checks++; if (o_issued0 !== 8'd1 || o_timeout !== 1'b1) begin failures++; $display("FAIL to_sticky: issued0 %0d timeout %b want 1 1", o_issued0, o_timeout); end
    apply_reset();
    checks++; if (o_timeout !== 1'b0) begin failures++; $display("FAIL to_clear: got %b want 0", o_timeout); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_free_ignored();
    test_reset_mid();
`ifdef ROUTE_ISSUER_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_route_issuer.md
SYNC_ROUTE_ISSUER -- requirements
Module: sync_route_issuer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue depth in entries; power of two, 2..16.
REQ-002 SHALL have parameter TIMEOUT, default 255, WAIT cycles before abort; 1..255.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port i_valid  input  1  upstream request valid.
REQ-006 SHALL have port o_ready  output  1  queue can accept a request.
REQ-007 SHALL have port i_dest  input  1  destination of the request; 0 = port 0, 1 = port 1.
REQ-008 SHALL have port o_drive  output  1  one-cycle drive pulse to the downstream two-way selector.
REQ-009 SHALL have port o_select  output  2  one-hot route to the selector; bit0 = port 0, bit1 = port 1.
REQ-010 SHALL have port i_free  input  1  completion (free) return from the selector.
REQ-011 SHALL have port o_busy  output  1  high while the FSM is not in IDLE.
REQ-012 SHALL have port o_issued0  output  8  count of completed port-0 transactions.
REQ-013 SHALL have port o_issued1  output  8  count of completed port-1 transactions.
REQ-014 SHALL have port o_timeout  output  1  sticky watchdog flag.

Function
REQ-015 SHALL store i_dest in a DEPTH-entry FIFO on every clock edge where i_valid and o_ready are both high.
REQ-016 SHALL drive o_ready = !full from the registered count; a push SHALL NOT be accepted when full, even if a pop occurs in the same cycle.
REQ-017 SHALL handle a simultaneous push and pop (not full) with count unchanged and both the write and read pointers advancing.
REQ-018 SHALL wrap the read and write pointers modulo DEPTH.
REQ-019 SHALL implement the FSM states IDLE, DRIVE and WAIT.
REQ-020 SHALL, in IDLE with the FIFO non-empty, go to DRIVE and register o_select = one-hot(head).
REQ-021 SHALL, in DRIVE, assert o_drive for exactly one cycle, then go to WAIT.
REQ-022 SHALL ignore i_free during IDLE and DRIVE.
REQ-023 SHALL, in WAIT, hold o_select stable until i_free is sampled high.
REQ-024 SHALL, on i_free sampled high in WAIT: pop the head, increment o_issued0 or o_issued1 per the popped destination (wrap 255 -> 0), and return to IDLE.
REQ-025 SHALL drive o_select = 2'b00 in IDLE.
REQ-026 SHALL NOT allow o_select to be 2'b11 or to change while o_drive is high or the FSM is in WAIT.
REQ-027 SHALL meet this latency: push accepted at edge N into an empty FIFO -> o_drive high in the cycle after edge N+1.
REQ-028 SHALL limit throughput to at most one transaction per 3 cycles.

Reset
REQ-029 SHALL, on rst high at a clock edge, set FIFO empty, FSM IDLE, o_drive = 0, o_select = 00, o_issued0 = o_issued1 = 0, o_timeout = 0, o_busy = 0.
REQ-030 SHALL reset to o_ready = 1.
REQ-031 SHALL, on rst mid-transaction, discard the in-flight entry and all queued entries.
REQ-032 SHALL ignore any i_free pulse arriving after reset.

Configuration
REQ-033 SHALL, with ROUTE_ISSUER_TIMEOUT_EN defined, count WAIT cycles without i_free (counter cleared on WAIT entry).
REQ-034 SHALL, with ROUTE_ISSUER_TIMEOUT_EN defined, on reaching TIMEOUT: set o_timeout sticky (cleared only by rst), pop the head without incrementing any counter, and go to IDLE.
REQ-035 SHALL give i_free priority over the watchdog when i_free arrives in the same cycle the watchdog expires (normal completion).
REQ-036 SHALL, without ROUTE_ISSUER_TIMEOUT_EN, wait in WAIT indefinitely, omit the watchdog counter and tie o_timeout to 0.

Verification
REQ-037 SHALL cover: push dest=1 into empty FIFO, i_free 2 cycles after drive -> o_drive pulse 2 cycles after push, o_select = 10 held through WAIT, o_issued1 = 1, o_select = 00 after.
REQ-038 SHALL cover: 5 pushes with DEPTH=4 and i_free held low -> o_ready low after the 4th push, 5th request stalled until the first completion.
REQ-039 SHALL cover: alternating dest 0,1,0,1 with i_free returned 1 cycle after each drive -> o_select sequence 01,10,01,10, o_issued0 = o_issued1 = 2, 3-cycle spacing.
REQ-040 SHALL cover: i_free pulse during DRIVE only -> ignored, FSM remains in WAIT.
REQ-041 SHALL cover: with ROUTE_ISSUER_TIMEOUT_EN, TIMEOUT=8 and no i_free -> o_timeout = 1 after 8 WAIT cycles, entry dropped, counters unchanged, next entry issued.
REQ-042 SHALL cover: rst asserted in WAIT with 3 entries queued -> next cycle all outputs at reset values, o_ready = 1.
